// File: rtl/dzcpu_uop_sequencer_pkg.sv
// Shared z80 micro-sequencer definitions: micro-op word layout, flow codes,
// micro-op mnemonics and sequencer state encodings.
package dzcpu_uop_sequencer_pkg;

  // Micro-op word field positions: flow[12:9], op[8:4], operand[3:0]
  localparam int FLOW_MSB    = 12;
  localparam int FLOW_LSB    = 9;
  localparam int OP_MSB      = 8;
  localparam int OP_LSB      = 4;
  localparam int OPERAND_MSB = 3;
  localparam int OPERAND_LSB = 0;

  // Flow codes carried in the top field of every micro-op
  localparam logic [3:0] FLOW_OP           = 4'd0;
  localparam logic [3:0] FLOW_INC          = 4'd1;
  localparam logic [3:0] FLOW_EOF          = 4'd2;
  localparam logic [3:0] FLOW_INC_EOF      = 4'd3;
  localparam logic [3:0] FLOW_EOF_FU       = 4'd4;
  localparam logic [3:0] FLOW_INC_EOF_FU   = 4'd5;
  localparam logic [3:0] FLOW_INC_EOF_Z    = 4'd6;
  localparam logic [3:0] FLOW_INC_EOF_NZ   = 4'd7;
  localparam logic [3:0] FLOW_UPDATE_FLAGS = 4'd8;

  // Micro-op mnemonics seen by the datapath
  localparam logic [4:0] UOP_NOP    = 5'h00;
  localparam logic [4:0] UOP_LOAD   = 5'h01;
  localparam logic [4:0] UOP_STORE  = 5'h02;
  localparam logic [4:0] UOP_ADD    = 5'h03;
  localparam logic [4:0] UOP_SUB    = 5'h04;
  localparam logic [4:0] UOP_BIT    = 5'h05;
  localparam logic [4:0] UOP_JMP    = 5'h06;
  // Jump into the CB-prefixed table; consumed by the sequencer itself
  localparam logic [4:0] UOP_JCB    = 5'h1F;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_FETCH     = 2'd0,
    ST_DECODE    = 2'd1,
    ST_CB_DECODE = 2'd2,
    ST_EXEC      = 2'd3
  } seq_state_t;

endpackage

// File: rtl/dzcpu_uop_flow_decode.sv
// Combinational decode of a micro-op flow code into sequencing actions.
module dzcpu_uop_flow_decode
  import dzcpu_uop_sequencer_pkg::*;
(
  input  logic [3:0] flow,
  input  logic       zflag,
  output logic       inc,
  output logic       fu,
  output logic       eof,
  output logic       suppress,
  output logic       illegal
);

  // Map each flow code to PC increment, flag write, finish and suppression
  always_comb begin
    inc      = 1'b0;
    fu       = 1'b0;
    eof      = 1'b0;
    suppress = 1'b0;
    illegal  = 1'b0;
    case (flow)
      FLOW_OP: begin
        eof = 1'b0;
      end
      FLOW_INC: begin
        inc = 1'b1;
      end
      FLOW_EOF: begin
        eof = 1'b1;
      end
      FLOW_INC_EOF: begin
        inc = 1'b1;
        eof = 1'b1;
      end
      FLOW_EOF_FU: begin
        fu  = 1'b1;
        eof = 1'b1;
      end
      FLOW_INC_EOF_FU: begin
        inc = 1'b1;
        fu  = 1'b1;
        eof = 1'b1;
      end
      // Conditional exit: the taken branch ends the flow without executing
      FLOW_INC_EOF_Z: begin
        inc      = 1'b1;
        eof      = zflag;
        suppress = zflag;
      end
      FLOW_INC_EOF_NZ: begin
        inc      = 1'b1;
        eof      = ~zflag;
        suppress = ~zflag;
      end
      FLOW_UPDATE_FLAGS: begin
        fu = 1'b1;
      end
      default: begin
        illegal  = 1'b1;
        suppress = 1'b1;
        eof      = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/dzcpu_uop_sequencer.sv
// Micro-op sequencer: fetches an opcode, looks up its micro-flow and steps
// the micro-PC through the micro-op ROM, handling the CB prefix table.
module dzcpu_uop_sequencer
  import dzcpu_uop_sequencer_pkg::*;
#(
  parameter int UOP_W = 13
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic [7:0]       iMemData,
  input  logic             iStall,
  input  logic             iZFlag,
  input  logic [7:0]       iFlowIdx,
  input  logic [7:0]       iCbFlowIdx,
  input  logic [UOP_W-1:0] iUop,
  output logic [7:0]       oLutMop,
  output logic [7:0]       oUopAddr,
  output logic [4:0]       oOp,
  output logic [3:0]       oOperand,
  output logic             oOpValid,
  output logic             oPcInc,
  output logic             oFlagsWe,
  output logic             oFetch,
  output logic             oIllegal
);

  seq_state_t state_reg;
  logic [7:0] upc_reg;
  logic [7:0] mop_reg;

  logic [3:0] uop_flow;
  logic       fd_inc;
  logic       fd_fu;
  logic       fd_eof;
  logic       fd_suppress;
  logic       fd_illegal;
  logic       is_jcb;
  logic       upc_at_end;

  assign uop_flow   = iUop[FLOW_MSB:FLOW_LSB];
  assign oOp        = iUop[OP_MSB:OP_LSB];
  assign oOperand   = iUop[OPERAND_MSB:OPERAND_LSB];
  assign is_jcb     = (iUop[OP_MSB:OP_LSB] == UOP_JCB);
  assign upc_at_end = (upc_reg == 8'hFF);
  assign oLutMop    = mop_reg;
  assign oUopAddr   = upc_reg;

  dzcpu_uop_flow_decode u_flow_decode (
    .flow     (uop_flow),
    .zflag    (iZFlag),
    .inc      (fd_inc),
    .fu       (fd_fu),
    .eof      (fd_eof),
    .suppress (fd_suppress),
    .illegal  (fd_illegal)
  );

  // Output decode from current state and micro-op; pulses only in an unstalled EXEC
  always_comb begin
    oFetch   = 1'b0;
    oOpValid = 1'b0;
    oPcInc   = 1'b0;
    oFlagsWe = 1'b0;
    oIllegal = 1'b0;
    case (state_reg)
      ST_FETCH: begin
        oFetch = 1'b1;
      end
      ST_EXEC: begin
        if (!iStall) begin
          if (fd_illegal) begin
            oIllegal = 1'b1;
          end else if (is_jcb) begin
            oPcInc = fd_inc;
          end else begin
            oOpValid = ~fd_suppress;
            oPcInc   = fd_inc;
            oFlagsWe = fd_fu;
            // Running off the end of the ROM is an error, not a silent wrap
            oIllegal = ~fd_eof & upc_at_end;
          end
        end
      end
      default: begin
        oFetch = 1'b0;
      end
    endcase
  end

  // State, micro-PC and opcode register update
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state_reg <= ST_FETCH;
      upc_reg   <= 8'h00;
      mop_reg   <= 8'h00;
    end else begin
      case (state_reg)
        ST_FETCH: begin
          if (!iStall) begin
            mop_reg   <= iMemData;
            state_reg <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          upc_reg   <= iFlowIdx;
          state_reg <= ST_EXEC;
        end
        ST_CB_DECODE: begin
          upc_reg   <= iCbFlowIdx;
          state_reg <= ST_EXEC;
        end
        ST_EXEC: begin
          if (!iStall) begin
            if (fd_illegal) begin
              state_reg <= ST_FETCH;
            end else if (is_jcb) begin
              mop_reg   <= iMemData;
              state_reg <= ST_CB_DECODE;
            end else if (fd_eof) begin
              state_reg <= ST_FETCH;
            end else begin
              upc_reg <= upc_reg + 8'd1;
              if (upc_at_end) begin
                state_reg <= ST_FETCH;
              end
            end
          end
        end
        default: begin
          state_reg <= ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dzcpu_uop_sequencer.sv
// Table-driven bench for the micro-op sequencer with a per-cycle scoreboard.
module tb_dzcpu_uop_sequencer;
  import dzcpu_uop_sequencer_pkg::*;

  logic        iClock;
  logic        iReset;
  logic [7:0]  iMemData;
  logic        iStall;
  logic        iZFlag;
  logic [7:0]  iFlowIdx;
  logic [7:0]  iCbFlowIdx;
  logic [12:0] iUop;
  logic [7:0]  oLutMop;
  logic [7:0]  oUopAddr;
  logic [4:0]  oOp;
  logic [3:0]  oOperand;
  logic        oOpValid;
  logic        oPcInc;
  logic        oFlagsWe;
  logic        oFetch;
  logic        oIllegal;

  // Bench-owned ROM and lookup tables
  logic [12:0] rom   [256];
  logic [7:0]  lut   [256];
  logic [7:0]  cblut [256];

  assign iUop       = rom[oUopAddr];
  assign iFlowIdx   = lut[oLutMop];
  assign iCbFlowIdx = cblut[oLutMop];

  dzcpu_uop_sequencer #(.UOP_W(13)) dut (
    .iClock     (iClock),
    .iReset     (iReset),
    .iMemData   (iMemData),
    .iStall     (iStall),
    .iZFlag     (iZFlag),
    .iFlowIdx   (iFlowIdx),
    .iCbFlowIdx (iCbFlowIdx),
    .iUop       (iUop),
    .oLutMop    (oLutMop),
    .oUopAddr   (oUopAddr),
    .oOp        (oOp),
    .oOperand   (oOperand),
    .oOpValid   (oOpValid),
    .oPcInc     (oPcInc),
    .oFlagsWe   (oFlagsWe),
    .oFetch     (oFetch),
    .oIllegal   (oIllegal)
  );

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  // ctl = {fetch, opvalid, pcinc, flagswe, illegal}
  localparam logic [4:0] C_NONE = 5'b00000;
  localparam logic [4:0] C_F    = 5'b10000;
  localparam logic [4:0] C_V    = 5'b01000;
  localparam logic [4:0] C_VI   = 5'b01100;
  localparam logic [4:0] C_VU   = 5'b01010;
  localparam logic [4:0] C_VIU  = 5'b01110;
  localparam logic [4:0] C_I    = 5'b00100;
  localparam logic [4:0] C_L    = 5'b00001;
  localparam logic [4:0] C_VL   = 5'b01001;

  typedef struct packed {
    logic       stall;
    logic [7:0] mem;
    logic       z;
    logic [4:0] ctl;
    logic       ca;
    logic [7:0] addr;
    logic       cm;
    logic [7:0] mop;
    logic [4:0] op;
  } vec_t;

  vec_t vecs [64];
  int   nv = 0;
  vec_t exp_q [$];
  int   n_checks = 0;
  int   n_err = 0;

  task automatic add(input logic stall, input logic [7:0] mem, input logic z,
                     input logic [4:0] ctl, input logic ca, input logic [7:0] addr,
                     input logic cm, input logic [7:0] mop, input logic [4:0] op);
    vec_t v;
    v.stall = stall; v.mem = mem; v.z = z; v.ctl = ctl;
    v.ca = ca; v.addr = addr; v.cm = cm; v.mop = mop; v.op = op;
    vecs[nv] = v;
    nv++;
  endtask

  task automatic check_now(input vec_t e, input string tag);
    logic [4:0] ctl;
    ctl = {oFetch, oOpValid, oPcInc, oFlagsWe, oIllegal};
    n_checks++;
    if (ctl !== e.ctl) begin
      n_err++;
      $display("FAIL %s ctl{fetch,valid,inc,fu,ill}: got %b want %b", tag, ctl, e.ctl);
    end
    if (e.ca) begin
      n_checks++;
      if (oUopAddr !== e.addr) begin
        n_err++;
        $display("FAIL %s uopaddr: got %0d want %0d", tag, oUopAddr, e.addr);
      end
    end
    if (e.cm) begin
      n_checks++;
      if (oLutMop !== e.mop) begin
        n_err++;
        $display("FAIL %s lutmop: got %02h want %02h", tag, oLutMop, e.mop);
      end
    end
    if (e.ctl[3]) begin
      n_checks++;
      if (oOp !== e.op) begin
        n_err++;
        $display("FAIL %s op: got %02h want %02h", tag, oOp, e.op);
      end
    end
    $display("txn %s: ctl=%b addr=%0d mop=%02h op=%02h", tag, ctl, oUopAddr, oLutMop, oOp);
  endtask

  // One clock of stimulus: drive after the edge, compare at the falling edge
  task automatic step(input vec_t v, input string tag);
    vec_t e;
    @(posedge iClock);
    #1;
    iStall   = v.stall;
    iMemData = v.mem;
    iZFlag   = v.z;
    exp_q.push_back(v);
    @(negedge iClock);
    e = exp_q.pop_front();
    check_now(e, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t r;
    for (int i = 0; i < 256; i++) begin
      rom[i]   = {FLOW_EOF, UOP_NOP, 4'h0};
      lut[i]   = 8'h00;
      cblut[i] = 8'h00;
    end
    // single micro-op instruction
    lut[8'h00] = 8'd0;   rom[0]   = {FLOW_INC_EOF, 5'd3, 4'd7};
    // CB prefix flow 13..15 ending in JCB, CB table entry at 16
    lut[8'hCB] = 8'd13;  rom[13]  = {FLOW_OP, 5'd1, 4'd0};
    rom[14] = {FLOW_INC, 5'd2, 4'd1};
    rom[15] = {FLOW_INC, UOP_JCB, 4'd0};
    cblut[8'h7C] = 8'd16; rom[16] = {FLOW_EOF_FU, 5'd4, 4'd2};
    // JRNZ-style flow 17..22
    lut[8'h20] = 8'd17;
    rom[17] = {FLOW_OP, 5'd6, 4'd0};
    rom[18] = {FLOW_INC, 5'd7, 4'd0};
    rom[19] = {FLOW_INC_EOF_Z, 5'd8, 4'd0};
    rom[20] = {FLOW_OP, 5'd9, 4'd1};
    rom[21] = {FLOW_OP, 5'd10, 4'd1};
    rom[22] = {FLOW_EOF, 5'd11, 4'd1};
    // stall target, illegal flow, ROM-end wrap
    lut[8'h31] = 8'd51;  rom[51]  = {FLOW_INC_EOF, 5'd12, 4'd3};
    lut[8'h40] = 8'd40;  rom[40]  = {4'd12, 5'd1, 4'd0};
    lut[8'hFF] = 8'd255; rom[255] = {FLOW_OP, 5'd2, 4'd0};
    // flag updates
    lut[8'h50] = 8'd60;
    rom[60] = {FLOW_UPDATE_FLAGS, 5'd5, 4'd0};
    rom[61] = {FLOW_INC_EOF_FU, 5'd5, 4'd1};
    // inverted conditional exit
    lut[8'h60] = 8'd70;
    rom[70] = {FLOW_INC_EOF_NZ, 5'd3, 4'd0};
    rom[71] = {FLOW_EOF, 5'd3, 4'd1};
    // reset-abandon flow
    lut[8'h70] = 8'd55;
    rom[55] = {FLOW_OP, 5'd1, 4'd0};
    rom[56] = {FLOW_EOF, 5'd1, 4'd0};

    // A: one micro-op instruction, 3-cycle latency
    add(0, 8'h00, 0, C_F,    1, 8'd0,   0, 8'h00, 5'd0);
    add(0, 8'h00, 0, C_NONE, 0, 8'd0,   1, 8'h00, 5'd0);
    add(0, 8'h00, 0, C_VI,   1, 8'd0,   0, 8'h00, 5'd3);
    // B: CB prefix
    add(0, 8'hCB, 0, C_F,    0, 8'd0,   0, 8'h00, 5'd0);
    add(0, 8'h00, 0, C_NONE, 0, 8'd0,   1, 8'hCB, 5'd0);
    add(0, 8'h00, 0, C_V,    1, 8'd13,  0, 8'h00, 5'd1);
    add(0, 8'h00, 0, C_VI,   1, 8'd14,  0, 8'h00, 5'd2);
    add(0, 8'h7C, 0, C_I,    1, 8'd15,  0, 8'h00, 5'd0);
    add(0, 8'h00, 0, C_NONE, 0, 8'd0,   1, 8'h7C, 5'd0);
    add(0, 8'h00, 0, C_VU,   1, 8'd16,  0, 8'h00, 5'd4);
    // C: conditional exit taken (Z=1)
    add(0, 8'h20, 0, C_F,    1, 8'd16,  0, 8'h00, 5'd0);
    add(0, 8'h00, 0, C_NONE, 0, 8'd0,   1, 8'h20, 5'd0);
    add(0, 8'h00, 1, C_V,    1, 8'd17,  0, 8'h00, 5'd6);
    add(0, 8'h00, 1, C_VI,   1, 8'd18,  0, 8'h00, 5'd7);
    add(0, 8'h00, 1, C_I,    1, 8'd19,  0, 8'h00, 5'd0);
    // D: conditional exit not taken (Z=0)
    add(0, 8'h20, 0, C_F,    1, 8'd19,  0, 8'h00, 5'd0);
    add(0, 8'h00, 0, C_NONE, 0, 8'd0,   1, 8'h20, 5'd0);
    add(0, 8'h00, 0, C_V,    1, 8'd17,  0, 8'h00, 5'd6);
    add(0, 8'h00, 0, C_VI,   1, 8'd18,  0, 8'h00, 5'd7);
    add(0, 8'h00, 0, C_VI,   1, 8'd19,  0, 8'h00, 5'd8);
    add(0, 8'h00, 0, C_V,    1, 8'd20,  0, 8'h00, 5'd9);
    add(0, 8'h00, 0, C_V,    1, 8'd21,  0, 8'h00, 5'd10);
    add(0, 8'h00, 0, C_V,    1, 8'd22,  0, 8'h00, 5'd11);
    // E: stall in FETCH, then 3 stalled EXEC cycles at 51
    add(1, 8'h00, 0, C_F,    1, 8'd22,  0, 8'h00, 5'd0);
    add(0, 8'h31, 0, C_F,    1, 8'd22,  0, 8'h00, 5'd0);
    add(0, 8'h00, 0, C_NONE, 0, 8'd0,   1, 8'h31, 5'd0);
    add(1, 8'h00, 0, C_NONE, 1, 8'd51,  0, 8'h00, 5'd0);
    add(1, 8'h00, 0, C_NONE, 1, 8'd51,  0, 8'h00, 5'd0);
    add(1, 8'h00, 0, C_NONE, 1, 8'd51,  0, 8'h00, 5'd0);
    add(0, 8'h00, 0, C_VI,   1, 8'd51,  0, 8'h00, 5'd12);
    // F: illegal flow code at 40
    add(0, 8'h40, 0, C_F,    1, 8'd51,  0, 8'h00, 5'd0);
    add(0, 8'h00, 0, C_NONE, 0, 8'd0,   1, 8'h40, 5'd0);
    add(0, 8'h00, 0, C_L,    1, 8'd40,  0, 8'h00, 5'd0);
    // G: non-finishing op at 255 wraps to 0
    add(0, 8'hFF, 0, C_F,    1, 8'd40,  0, 8'h00, 5'd0);
    add(0, 8'h00, 0, C_NONE, 0, 8'd0,   1, 8'hFF, 5'd0);
    add(0, 8'h00, 0, C_VL,   1, 8'd255, 0, 8'h00, 5'd2);
    // H: flag updates
    add(0, 8'h50, 0, C_F,    1, 8'd0,   0, 8'h00, 5'd0);
    add(0, 8'h00, 0, C_NONE, 0, 8'd0,   1, 8'h50, 5'd0);
    add(0, 8'h00, 0, C_VU,   1, 8'd60,  0, 8'h00, 5'd5);
    add(0, 8'h00, 0, C_VIU,  1, 8'd61,  0, 8'h00, 5'd5);
    // I: inverted condition, taken (Z=0) then not taken (Z=1)
    add(0, 8'h60, 0, C_F,    1, 8'd61,  0, 8'h00, 5'd0);
    add(0, 8'h00, 0, C_NONE, 0, 8'd0,   1, 8'h60, 5'd0);
    add(0, 8'h00, 0, C_I,    1, 8'd70,  0, 8'h00, 5'd0);
    add(0, 8'h60, 1, C_F,    1, 8'd70,  0, 8'h00, 5'd0);
    add(0, 8'h00, 1, C_NONE, 0, 8'd0,   1, 8'h60, 5'd0);
    add(0, 8'h00, 1, C_VI,   1, 8'd70,  0, 8'h00, 5'd3);
    add(0, 8'h00, 1, C_V,    1, 8'd71,  0, 8'h00, 5'd3);

    // reset
    iReset   = 1'b1;
    iStall   = 1'b1;
    iMemData = 8'h00;
    iZFlag   = 1'b0;
    @(negedge iClock);
    r = '0; r.ctl = C_F; r.ca = 1'b1; r.addr = 8'd0; r.cm = 1'b1; r.mop = 8'h00;
    check_now(r, "in_reset");
    repeat (2) @(posedge iClock);
    #1 iReset = 1'b0;
    @(negedge iClock);
    check_now(r, "post_reset");

    for (int i = 0; i < nv; i++) begin
      step(vecs[i], $sformatf("v%0d", i));
    end

    // reset asserted mid-EXEC at uPC 55
    r = '0; r.mem = 8'h70; r.ctl = C_F;
    step(r, "rst_fetch");
    r = '0; r.ctl = C_NONE; r.cm = 1'b1; r.mop = 8'h70;
    step(r, "rst_decode");
    r = '0; r.ctl = C_V; r.ca = 1'b1; r.addr = 8'd55; r.op = 5'd1;
    step(r, "rst_exec55");
    #2 iReset = 1'b1;
    #1;
    r = '0; r.ctl = C_F; r.ca = 1'b1; r.addr = 8'd0; r.cm = 1'b1; r.mop = 8'h00;
    check_now(r, "rst_async");
    iStall = 1'b1;
    @(posedge iClock);
    @(posedge iClock);
    #1 iReset = 1'b0;
    @(negedge iClock);
    check_now(r, "rst_release");
    r = '0; r.ctl = C_F; r.ca = 1'b1; r.addr = 8'd0;
    step(r, "after_rst_fetch");
    r = '0; r.ctl = C_NONE; r.cm = 1'b1; r.mop = 8'h00;
    step(r, "after_rst_decode");
    r = '0; r.ctl = C_VI; r.ca = 1'b1; r.addr = 8'd0; r.op = 5'd3;
    step(r, "after_rst_exec");
    r = '0; r.ctl = C_F; r.stall = 1'b1;
    step(r, "after_rst_refetch");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
